// File: rtl/udp_rx_unpack_if.sv
// Byte-in / word-out stream bundle for udp_rx_unpack.
// slave: the unpacker's view (consumes bytes, produces words).
// master: the view of whatever drives bytes in and sinks words out.
interface udp_rx_unpack_if #(
  parameter int OUT_BYTES = 4
);
  logic [7:0]             udp_axis_tdata_in;
  logic                   udp_axis_tvalid_in;
  logic                   udp_axis_tlast_in;
  logic                   udp_axis_tready_out;
  logic [OUT_BYTES*8-1:0] udp_axis_tdata_out;
  logic [OUT_BYTES-1:0]   udp_axis_tkeep_out;
  logic                   udp_axis_tvalid_out;
  logic                   udp_axis_tlast_out;
  logic                   udp_axis_tready_in;

  modport slave (
    input  udp_axis_tdata_in, udp_axis_tvalid_in, udp_axis_tlast_in, udp_axis_tready_in,
    output udp_axis_tready_out, udp_axis_tdata_out, udp_axis_tkeep_out,
           udp_axis_tvalid_out, udp_axis_tlast_out
  );

  modport master (
    output udp_axis_tdata_in, udp_axis_tvalid_in, udp_axis_tlast_in, udp_axis_tready_in,
    input  udp_axis_tready_out, udp_axis_tdata_out, udp_axis_tkeep_out,
           udp_axis_tvalid_out, udp_axis_tlast_out
  );
endinterface

// File: rtl/udp_rx_unpack.sv
// UDP receive unpacker: strips the 8-byte UDP header into field registers
// and packs the payload bytes MSB-lane first into OUT_BYTES-wide words.
// Single output register; input is stalled only while that register is
// full and not draining, so every accepted payload byte always has room.
module udp_rx_unpack #(
  parameter int OUT_BYTES = 4,
  parameter int CNT_W     = 16
) (
  input  logic           clk,
  input  logic           reset,
  udp_rx_unpack_if.slave axis,
  output logic [15:0]    src_port_out,
  output logic [15:0]    dst_port_out,
  output logic [15:0]    udp_length_out,
  output logic [15:0]    checksum_out,
  output logic           hdr_valid_out,
  output logic           err_len_out,
  output logic           err_short_out
);
  localparam int LW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam logic [0:0] S_HDR     = 1'b0;
  localparam logic [0:0] S_PAYLOAD = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [LW-1:0]    LANE_LAST = LW'(OUT_BYTES - 1);

  logic [0:0]             state;
  logic [CNT_W-1:0]       byte_cnt;
  logic [LW-1:0]          lane_idx;
  logic [55:0]            hdr_sh;    // header bytes 0..6, byte 0 oldest
  logic [OUT_BYTES*8-1:0] pk_data;   // partially packed payload word

  logic                   accept, last_acc, hdr_byte7, word_done;
  logic [63:0]            hdr_full;
  logic [CNT_W-1:0]       byte_total;
  logic [15:0]            len_field;
  logic [OUT_BYTES*8-1:0] word_next;
  logic [OUT_BYTES-1:0]   keep_next;

  assign axis.udp_axis_tready_out = ~axis.udp_axis_tvalid_out | axis.udp_axis_tready_in;
  assign accept     = axis.udp_axis_tvalid_in & axis.udp_axis_tready_out;
  assign last_acc   = accept & axis.udp_axis_tlast_in;
  assign hdr_byte7  = accept && (state == S_HDR) && (byte_cnt == CNT_W'(7));
  assign hdr_full   = {hdr_sh, axis.udp_axis_tdata_in};
  // Count including the byte being accepted now, pinned at all-ones.
  assign byte_total = (byte_cnt == CNT_MAX) ? CNT_MAX : byte_cnt + CNT_W'(1);
  // A datagram ending on byte 7 has not yet published its length field.
  assign len_field  = (state == S_HDR) ? hdr_full[31:16] : udp_length_out;
  assign word_done  = accept && (state == S_PAYLOAD) &&
                      ((lane_idx == LANE_LAST) || axis.udp_axis_tlast_in);

  // Merge the incoming byte into its lane and build the keep mask.
  always_comb begin
    word_next = pk_data;
    keep_next = '0;
    for (int k = 0; k < OUT_BYTES; k++) begin
      if (LW'(k) == lane_idx) word_next[8*(OUT_BYTES-1-k) +: 8] = axis.udp_axis_tdata_in;
      keep_next[OUT_BYTES-1-k] = (LW'(k) <= lane_idx);
    end
  end

  // Parser state, byte counter, header shift register and packing buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_HDR;
      byte_cnt <= '0;
      lane_idx <= '0;
      hdr_sh   <= '0;
      pk_data  <= '0;
    end else if (accept) begin
      byte_cnt <= axis.udp_axis_tlast_in ? '0 : byte_total;
      if (state == S_HDR) begin
        hdr_sh <= {hdr_sh[47:0], axis.udp_axis_tdata_in};
        if ((byte_cnt == CNT_W'(7)) && !axis.udp_axis_tlast_in) state <= S_PAYLOAD;
      end else begin
        if (word_done) begin
          pk_data  <= '0;
          lane_idx <= '0;
        end else begin
          pk_data  <= word_next;
          lane_idx <= lane_idx + LW'(1);
        end
        if (axis.udp_axis_tlast_in) state <= S_HDR;
      end
    end
  end

  // Publish header fields once all eight header bytes are in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_port_out   <= '0;
      dst_port_out   <= '0;
      udp_length_out <= '0;
      checksum_out   <= '0;
      hdr_valid_out  <= 1'b0;
    end else begin
      hdr_valid_out <= hdr_byte7;
      if (hdr_byte7) begin
        src_port_out   <= hdr_full[63:48];
        dst_port_out   <= hdr_full[47:32];
        udp_length_out <= hdr_full[31:16];
        checksum_out   <= hdr_full[15:0];
      end
    end
  end

  // Error pulses: truncated header, or total size disagreeing with length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_short_out <= 1'b0;
      err_len_out   <= 1'b0;
    end else begin
      err_short_out <= last_acc && (state == S_HDR) && (byte_cnt < CNT_W'(7));
      err_len_out   <= last_acc && ((state == S_PAYLOAD) || (byte_cnt == CNT_W'(7))) &&
                       ((byte_total != CNT_W'(len_field)) || (len_field < 16'd8));
    end
  end

  // Output word register: load on word completion, otherwise drain when taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      axis.udp_axis_tdata_out  <= '0;
      axis.udp_axis_tkeep_out  <= '0;
      axis.udp_axis_tvalid_out <= 1'b0;
      axis.udp_axis_tlast_out  <= 1'b0;
    end else if (word_done) begin
      axis.udp_axis_tdata_out  <= word_next;
      axis.udp_axis_tkeep_out  <= keep_next;
      axis.udp_axis_tvalid_out <= 1'b1;
      axis.udp_axis_tlast_out  <= axis.udp_axis_tlast_in;
    end else if (axis.udp_axis_tready_in) begin
      axis.udp_axis_tdata_out  <= '0;
      axis.udp_axis_tkeep_out  <= '0;
      axis.udp_axis_tvalid_out <= 1'b0;
      axis.udp_axis_tlast_out  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_udp_rx_unpack.sv
// Bench for udp_rx_unpack: three instances (4, 1 and 8 lanes) fed the same
// accepted byte stream, a datagram-level reference model with per-instance
// word scoreboards, a directed vector table and a randomized phase.
module tb_udp_rx_unpack;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] tb_data;
  logic       tb_valid, tb_last, rdy4;
  int         rdy_mode;   // 0: always ready, 1: random, 2: held low

  udp_rx_unpack_if #(.OUT_BYTES(4)) if4 ();
  udp_rx_unpack_if #(.OUT_BYTES(1)) if1 ();
  udp_rx_unpack_if #(.OUT_BYTES(8)) if8 ();

  logic [15:0] s4, d4, l4, c4, s1, d1, l1, c1, s8, d8, l8, c8;
  logic        hv4, el4, es4, hv1, el1, es1, hv8, el8, es8;

  // The 1- and 8-lane copies accept exactly the bytes the 4-lane one accepts.
  assign if4.udp_axis_tdata_in  = tb_data;
  assign if4.udp_axis_tvalid_in = tb_valid;
  assign if4.udp_axis_tlast_in  = tb_last;
  assign if4.udp_axis_tready_in = rdy4;
  assign if1.udp_axis_tdata_in  = tb_data;
  assign if1.udp_axis_tvalid_in = tb_valid & if4.udp_axis_tready_out;
  assign if1.udp_axis_tlast_in  = tb_last;
  assign if1.udp_axis_tready_in = 1'b1;
  assign if8.udp_axis_tdata_in  = tb_data;
  assign if8.udp_axis_tvalid_in = tb_valid & if4.udp_axis_tready_out;
  assign if8.udp_axis_tlast_in  = tb_last;
  assign if8.udp_axis_tready_in = 1'b1;

  udp_rx_unpack #(.OUT_BYTES(4), .CNT_W(16)) dut4 (
    .clk(clk), .reset(reset), .axis(if4),
    .src_port_out(s4), .dst_port_out(d4), .udp_length_out(l4), .checksum_out(c4),
    .hdr_valid_out(hv4), .err_len_out(el4), .err_short_out(es4));
  udp_rx_unpack #(.OUT_BYTES(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .axis(if1),
    .src_port_out(s1), .dst_port_out(d1), .udp_length_out(l1), .checksum_out(c1),
    .hdr_valid_out(hv1), .err_len_out(el1), .err_short_out(es1));
  udp_rx_unpack #(.OUT_BYTES(8), .CNT_W(16)) dut8 (
    .clk(clk), .reset(reset), .axis(if8),
    .src_port_out(s8), .dst_port_out(d8), .udp_length_out(l8), .checksum_out(c8),
    .hdr_valid_out(hv8), .err_len_out(el8), .err_short_out(es8));

  typedef struct packed {
    logic [63:0] data;   // right-aligned, OUT_BYTES*8 bits used
    logic [7:0]  keep;
    logic        last;
  } word_t;

  typedef struct {
    logic [15:0] src, dst, len, ck;
    int          n;       // total datagram bytes
    logic [63:0] pl;      // payload bytes, first byte in [63:56]
    int          words;   // expected 4-lane words
    logic [31:0] ldata;   // expected last 4-lane word
    logic [3:0]  lkeep;
    int          hdr, el, es;
  } vec_t;

  word_t       q0[$], q1[$], q2[$];
  word_t       lastw[3];
  int          wcnt[3], hcnt[3], elcnt[3], escnt[3];
  int          exp_h = 0, exp_el = 0, exp_es = 0;
  logic [63:0] exp_hdr = '0;
  logic [7:0]  dg[$];
  int          checks = 0, errors = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: chop the payload into OUT_BYTES chunks, left-aligned.
  task automatic model(input int n_sent, input bit complete);
    int np, cnt, ob, i;
    word_t w;
    logic [15:0] lf;
    if (n_sent >= 8) begin
      exp_hdr = {dg[0], dg[1], dg[2], dg[3], dg[4], dg[5], dg[6], dg[7]};
      exp_h++;
    end
    if (complete) begin
      if (n_sent < 8) exp_es++;
      else begin
        lf = {dg[4], dg[5]};
        if (n_sent != int'(lf) || lf < 16'd8) exp_el++;
      end
    end
    np = n_sent - 8;
    for (int d = 0; d < 3; d++) begin
      ob = (d == 0) ? 4 : (d == 1) ? 1 : 8;
      i = 0;
      while (i < np) begin
        cnt = (np - i < ob) ? np - i : ob;
        if (cnt < ob && !complete) break;
        w.data = '0;
        for (int j = 0; j < ob; j++)
          w.data = (w.data << 8) | 64'((j < cnt) ? dg[8+i+j] : 8'h00);
        w.keep = 8'(((1 << cnt) - 1) << (ob - cnt));
        w.last = complete && (i + cnt == np);
        case (d)
          0: q0.push_back(w);
          1: q1.push_back(w);
          default: q2.push_back(w);
        endcase
        i += cnt;
      end
    end
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic [63:0] dat,
                     input logic [7:0] kp, input logic lst, input logic hv,
                     input logic [63:0] hf, input logic el, input logic es);
    word_t a, e;
    bit got;
    got = 0;
    e = '0;
    if (v && r) begin
      a.data = dat; a.keep = kp; a.last = lst;
      wcnt[d]++;
      lastw[d] = a;
      case (d)
        0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1; end
      endcase
      if (got) chk($sformatf("word_dut%0d", d), 80'(a), 80'(e));
      else begin
        checks++; errors++;
        $display("FAIL word_dut%0d: got %h expected no word", d, a);
      end
    end
    if (hv) begin
      hcnt[d]++;
      chk($sformatf("hdr_fields_dut%0d", d), 80'(hf), 80'(exp_hdr));
    end
    if (el) elcnt[d]++;
    if (es) escnt[d]++;
  endtask

  // Output monitor plus hold-stable check on the back-pressured instance.
  initial begin
    bit          stall;
    logic [41:0] held;
    stall = 0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (reset) stall = 0;
      else begin
        mon(0, if4.udp_axis_tvalid_out, if4.udp_axis_tready_in, 64'(if4.udp_axis_tdata_out),
            8'(if4.udp_axis_tkeep_out), if4.udp_axis_tlast_out, hv4, {s4, d4, l4, c4}, el4, es4);
        mon(1, if1.udp_axis_tvalid_out, if1.udp_axis_tready_in, 64'(if1.udp_axis_tdata_out),
            8'(if1.udp_axis_tkeep_out), if1.udp_axis_tlast_out, hv1, {s1, d1, l1, c1}, el1, es1);
        mon(2, if8.udp_axis_tvalid_out, if8.udp_axis_tready_in, 64'(if8.udp_axis_tdata_out),
            8'(if8.udp_axis_tkeep_out), if8.udp_axis_tlast_out, hv8, {s8, d8, l8, c8}, el8, es8);
        if (stall)
          chk("hold_stable", 80'({if4.udp_axis_tvalid_out, if4.udp_axis_tlast_out,
              if4.udp_axis_tkeep_out, if4.udp_axis_tdata_out}), 80'(held));
        stall = if4.udp_axis_tvalid_out && !if4.udp_axis_tready_in;
        held  = {if4.udp_axis_tvalid_out, if4.udp_axis_tlast_out,
                 if4.udp_axis_tkeep_out, if4.udp_axis_tdata_out};
      end
    end
  end

  // Downstream ready generator for the 4-lane instance.
  initial begin
    rdy4 = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: rdy4 = 1'b1;
        1: rdy4 = ($urandom_range(0, 9) < 7);
        default: rdy4 = 1'b0;
      endcase
    end
  end

  task automatic send(input int n_sent, input bit complete, input bit gaps);
    int   to;
    logic r;
    for (int i = 0; i < n_sent; i++) begin
      if (gaps)
        while ($urandom_range(0, 3) == 0) begin
          tb_valid = 1'b0;
          tb_last  = 1'($urandom_range(0, 1));
          tb_data  = 8'($urandom);
          @(posedge clk); #1;
        end
      tb_valid = 1'b1;
      tb_data  = dg[i];
      tb_last  = complete && (i == n_sent - 1);
      to = 0;
      forever begin
        @(negedge clk);
        r = if4.udp_axis_tready_out;
        @(posedge clk); #1;
        if (r) break;
        to++;
        if (to > 500) begin
          $display("FAIL send_timeout: byte %0d not accepted within 500 cycles", i);
          $fatal(1, "input stalled");
        end
      end
    end
    tb_valid = 1'b0;
    tb_last  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() > 0 || q1.size() > 0 || q2.size() > 0 || if4.udp_axis_tvalid_out) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_done", 80'(t < 300), 80'(1));
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_tvalid"}, 80'(if4.udp_axis_tvalid_out), 80'(0));
    chk({p, "_tlast"},  80'(if4.udp_axis_tlast_out), 80'(0));
    chk({p, "_tdata"},  80'(if4.udp_axis_tdata_out), 80'(0));
    chk({p, "_tkeep"},  80'(if4.udp_axis_tkeep_out), 80'(0));
    chk({p, "_tready"}, 80'(if4.udp_axis_tready_out), 80'(1));
    chk({p, "_hdr"},    80'({s4, d4, l4, c4}), 80'(0));
    chk({p, "_pulses"}, 80'({hv4, el4, es4}), 80'(0));
    chk({p, "_other_tvalid"}, 80'({if1.udp_axis_tvalid_out, if8.udp_axis_tvalid_out}), 80'(0));
  endtask

  vec_t        tbl[9];
  logic [63:0] tab_hdr;

  task automatic build(input int k);
    dg.delete();
    dg.push_back(tbl[k].src[15:8]); dg.push_back(tbl[k].src[7:0]);
    dg.push_back(tbl[k].dst[15:8]); dg.push_back(tbl[k].dst[7:0]);
    dg.push_back(tbl[k].len[15:8]); dg.push_back(tbl[k].len[7:0]);
    dg.push_back(tbl[k].ck[15:8]);  dg.push_back(tbl[k].ck[7:0]);
    for (int b = 0; b < 8; b++) dg.push_back(tbl[k].pl[63-8*b -: 8]);
    while (dg.size() > tbl[k].n) void'(dg.pop_back());
  endtask

  initial begin
    int w0, w1, w2, h0, e0, s0, n;
    logic [15:0] lf;
    tbl[0] = '{16'h1234, 16'h5678, 16'h000C, 16'hABCD, 12, 64'hDEADBEEF_00000000, 1, 32'hDEADBEEF, 4'hF, 1, 0, 0};
    tbl[1] = '{16'h1111, 16'h2222, 16'h000E, 16'h3333, 14, 64'h01020304_05060000, 2, 32'h05060000, 4'hC, 1, 0, 0};
    tbl[2] = '{16'hAAAA, 16'hBBBB, 16'h0005, 16'h0000,  5, 64'h0,                 0, 32'h0,        4'h0, 0, 0, 1};
    tbl[3] = '{16'h1234, 16'h5678, 16'h0010, 16'hABCD, 12, 64'hDEADBEEF_00000000, 1, 32'hDEADBEEF, 4'hF, 1, 1, 0};
    tbl[4] = '{16'h0102, 16'h0304, 16'h0008, 16'h0506,  8, 64'h0,                 0, 32'h0,        4'h0, 1, 0, 0};
    tbl[5] = '{16'h0F0F, 16'hF0F0, 16'h0005, 16'h1234,  8, 64'h0,                 0, 32'h0,        4'h0, 1, 1, 0};
    tbl[6] = '{16'hCAFE, 16'hBEEF, 16'h0009, 16'h0000,  9, 64'h77000000_00000000, 1, 32'h77000000, 4'h8, 1, 0, 0};
    tbl[7] = '{16'h9900, 16'h0000, 16'h0000, 16'h0000,  1, 64'h0,                 0, 32'h0,        4'h0, 0, 0, 1};
    tbl[8] = '{16'h4321, 16'h8765, 16'h0010, 16'h0F0F, 16, 64'h10203040_50607080, 2, 32'h50607080, 4'hF, 1, 0, 0};
    for (int d = 0; d < 3; d++) begin
      wcnt[d] = 0; hcnt[d] = 0; elcnt[d] = 0; escnt[d] = 0; lastw[d] = '0;
    end
    tab_hdr  = '0;
    rdy_mode = 0;
    tb_valid = 1'b0; tb_last = 1'b0; tb_data = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors.
    for (int k = 0; k < 9; k++) begin
      w0 = wcnt[0]; w1 = wcnt[1]; w2 = wcnt[2];
      h0 = hcnt[0]; e0 = elcnt[0]; s0 = escnt[0];
      build(k);
      model(tbl[k].n, 1);
      send(tbl[k].n, 1, 0);
      drain();
      if (tbl[k].hdr != 0) tab_hdr = {tbl[k].src, tbl[k].dst, tbl[k].len, tbl[k].ck};
      chk($sformatf("t%0d_words", k), 80'(wcnt[0] - w0), 80'(tbl[k].words));
      if (tbl[k].words > 0) begin
        chk($sformatf("t%0d_last_data", k), 80'(lastw[0].data[31:0]), 80'(tbl[k].ldata));
        chk($sformatf("t%0d_last_keep", k), 80'(lastw[0].keep[3:0]), 80'(tbl[k].lkeep));
        chk($sformatf("t%0d_last_flag", k), 80'(lastw[0].last), 80'(1));
      end
      chk($sformatf("t%0d_hdr_pulses", k), 80'(hcnt[0] - h0), 80'(tbl[k].hdr));
      chk($sformatf("t%0d_err_len", k), 80'(elcnt[0] - e0), 80'(tbl[k].el));
      chk($sformatf("t%0d_err_short", k), 80'(escnt[0] - s0), 80'(tbl[k].es));
      chk($sformatf("t%0d_hdr_out", k), 80'({s4, d4, l4, c4}), 80'(tab_hdr));
      if (k == 0) begin
        chk("t0_ob1_words", 80'(wcnt[1] - w1), 80'(4));
        chk("t0_ob1_last", 80'({lastw[1].data, lastw[1].keep, lastw[1].last}),
            80'({64'hEF, 8'h01, 1'b1}));
        chk("t0_ob8_words", 80'(wcnt[2] - w2), 80'(1));
        chk("t0_ob8_last", 80'({lastw[2].data, lastw[2].keep, lastw[2].last}),
            80'({64'hDEADBEEF_00000000, 8'hF0, 1'b1}));
      end
    end

    // Downstream stall of 5 cycles across the 14-byte datagram.
    w0 = wcnt[0];
    build(1);
    model(14, 1);
    rdy_mode = 2;
    fork
      send(14, 1, 0);
      begin
        int t;
        t = 0;
        while (!if4.udp_axis_tvalid_out && t < 100) begin @(negedge clk); t++; end
        chk("bp_word_seen", 80'(t < 100), 80'(1));
        repeat (5) begin
          @(negedge clk);
          chk("bp_tready_out", 80'(if4.udp_axis_tready_out), 80'(0));
          chk("bp_data", 80'({if4.udp_axis_tvalid_out, if4.udp_axis_tdata_out}), 80'({1'b1, 32'h01020304}));
        end
        rdy_mode = 0;
      end
    join
    drain();
    chk("bp_words", 80'(wcnt[0] - w0), 80'(2));
    chk("bp_last", 80'({lastw[0].data[31:0], lastw[0].keep[3:0], lastw[0].last}),
        80'({32'h05060000, 4'hC, 1'b1}));

    // Reset after payload byte 2, then a clean datagram.
    build(1);
    model(10, 0);
    send(10, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset("mid_reset");
    exp_hdr = '0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    w0 = wcnt[0];
    build(0);
    model(12, 1);
    send(12, 1, 0);
    drain();
    chk("post_reset_words", 80'(wcnt[0] - w0), 80'(1));
    chk("post_reset_word", 80'({lastw[0].data[31:0], lastw[0].keep[3:0], lastw[0].last}),
        80'({32'hDEADBEEF, 4'hF, 1'b1}));
    chk("post_reset_hdr", 80'({s4, d4, l4, c4}), 80'(64'h1234_5678_000C_ABCD));

    // Randomized datagrams with gaps and random downstream ready.
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(1, 24);
      dg.delete();
      for (int b = 0; b < n; b++) dg.push_back(8'($urandom));
      if ($urandom_range(0, 3) != 0 && n >= 6) begin
        lf = 16'(n);
        dg[4] = lf[15:8];
        dg[5] = lf[7:0];
      end
      model(n, 1);
      send(n, 1, 1);
    end
    rdy_mode = 0;
    drain();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("final_hdr_count_dut%0d", d), 80'(hcnt[d]), 80'(exp_h));
      chk($sformatf("final_err_len_dut%0d", d), 80'(elcnt[d]), 80'(exp_el));
      chk($sformatf("final_err_short_dut%0d", d), 80'(escnt[d]), 80'(exp_es));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
